// File: rtl/psram_arb_pkg.sv
// psram_arb_pkg: shared widths and the FSM state encoding for psram_arbiter.
//   PSRAM_ADDR_W / PSRAM_DATA_W / PSRAM_SIZE_W : controller field widths
//   arb_state_e                                : IDLE=0, ISSUE=1, WAIT=2, RESP=3
package psram_arb_pkg;
    localparam int PSRAM_ADDR_W = 24;
    localparam int PSRAM_DATA_W = 32;
    localparam int PSRAM_SIZE_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;
endpackage

// File: rtl/psram_arbiter_if.sv
// psram_arbiter_if: requester-side and controller-side bundle of psram_arbiter.
//   Requester side : req_valid/addr/rd_wr/size/wdata in, grant/resp_done/
//                    resp_err/resp_rdata/busy out (flat vectors, lane i at [W*i +: W]).
//   Controller side: ctrl_addr/wdata/size/rd_wr/start out, ctrl_rdata/done in.
//   slave  : arbiter view.  master : environment (requesters + controller) view.
interface psram_arbiter_if
    import psram_arb_pkg::*;
#(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ*PSRAM_ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]              req_rd_wr;
    logic [NUM_REQ*PSRAM_SIZE_W-1:0] req_size;
    logic [NUM_REQ*PSRAM_DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]              grant;
    logic [NUM_REQ-1:0]              resp_done;
    logic                            resp_err;
    logic [PSRAM_DATA_W-1:0]         resp_rdata;
    logic                            busy;
    logic [PSRAM_ADDR_W-1:0]         ctrl_addr;
    logic [PSRAM_DATA_W-1:0]         ctrl_wdata;
    logic [PSRAM_SIZE_W-1:0]         ctrl_size;
    logic                            ctrl_rd_wr;
    logic                            ctrl_start;
    logic [PSRAM_DATA_W-1:0]         ctrl_rdata;
    logic                            ctrl_done;

    modport slave (
        input  req_valid, req_addr, req_rd_wr, req_size, req_wdata,
        input  ctrl_rdata, ctrl_done,
        output grant, resp_done, resp_err, resp_rdata, busy,
        output ctrl_addr, ctrl_wdata, ctrl_size, ctrl_rd_wr, ctrl_start
    );

    modport master (
        output req_valid, req_addr, req_rd_wr, req_size, req_wdata,
        output ctrl_rdata, ctrl_done,
        input  grant, resp_done, resp_err, resp_rdata, busy,
        input  ctrl_addr, ctrl_wdata, ctrl_size, ctrl_rd_wr, ctrl_start
    );
endinterface

// File: rtl/psram_rr_pick.sv
// psram_rr_pick: combinational round-robin picker.
//   req_i     : request vector
//   ptr_i     : index where the search starts (wraps past NUM_REQ-1 to 0)
//   onehot_o  : one-hot winner, idx_o : winner index, any_o : some request set
module psram_rr_pick
    import psram_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] onehot_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int j;
            // ptr_i < NUM_REQ always, so one conditional subtract wraps it
            j = int'(ptr_i) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!any_o && req_i[j]) begin
                any_o       = 1'b1;
                onehot_o[j] = 1'b1;
                idx_o       = IDX_W'(j);
            end
        end
    end
endmodule

// File: rtl/psram_arbiter.sv
// psram_arbiter: shares one PSRAM controller among NUM_REQ requesters,
// round-robin, one transaction at a time (IDLE -> ISSUE -> WAIT -> RESP).
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : psram_arbiter_if slave (requester handshake + controller fields)
module psram_arbiter
    import psram_arb_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic           clk,
    input  logic           rst,
    psram_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    arb_state_e              state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PSRAM_ADDR_W-1:0] addr_q, addr_d;
    logic [PSRAM_DATA_W-1:0] wdata_q, wdata_d;
    logic [PSRAM_SIZE_W-1:0] size_q, size_d;
    logic                    rd_wr_q, rd_wr_d;
    logic [PSRAM_DATA_W-1:0] rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic [NUM_REQ-1:0]      pick_onehot;
    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_any;

    psram_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i    (bus.req_valid),
        .ptr_i    (ptr_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            rd_wr_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            rd_wr_q <= rd_wr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        rd_wr_d = rd_wr_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                // Requester inputs are only looked at here; the ctrl_* regs
                // then hold still until the next IDLE win.
                if (pick_any) begin
                    grant_d = pick_onehot;
                    addr_d  = bus.req_addr[pick_idx*PSRAM_ADDR_W +: PSRAM_ADDR_W];
                    wdata_d = bus.req_wdata[pick_idx*PSRAM_DATA_W +: PSRAM_DATA_W];
                    size_d  = bus.req_size[pick_idx*PSRAM_SIZE_W +: PSRAM_SIZE_W];
                    rd_wr_d = bus.req_rd_wr[pick_idx];
                    ptr_d   = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // done is checked first so it wins over a same-cycle expiry
                if (bus.ctrl_done) begin
                    rdata_d = rd_wr_q ? bus.ctrl_rdata : '0;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.grant      = grant_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.ctrl_start = (state_q == ST_ISSUE);
    assign bus.resp_done  = (state_q == ST_RESP) ? grant_q : '0;
    assign bus.resp_err   = (state_q == ST_RESP) && err_q;
    assign bus.resp_rdata = (state_q == ST_RESP) ? rdata_q : '0;
    assign bus.ctrl_addr  = addr_q;
    assign bus.ctrl_wdata = wdata_q;
    assign bus.ctrl_size  = size_q;
    assign bus.ctrl_rd_wr = rd_wr_q;
endmodule

// File: doc/psram_arbiter.md
# psram_arbiter

- Shares a single `EF_PSRAM_CTRL_V2` instance among up to `NUM_REQ` requesters (weight loader, bias loader, result store, ...).
- Arbitration is round-robin.
- Runs one transaction at a time: latches the winner's command, pulses the controller start, waits for done or timeout, then returns read data and status to the winner.
- Sits between the conv/dense layer engines and the PSRAM controller.

## Interface
Parameters:
- `NUM_REQ`, 3, number of requesters (2..8)
- `TIMEOUT_CYCLES`, 1024, max cycles waiting for `ctrl_done` before error (≥16)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  NUM_REQ  per-requester request, held until its `resp_done`
- `req_addr`  in  NUM_REQ*24  byte address, requester i at [24i+:24]
- `req_rd_wr`  in  NUM_REQ  1 = read, 0 = write
- `req_size`  in  NUM_REQ*3  transfer size code, passed through
- `req_wdata`  in  NUM_REQ*32  write data
- `grant`  out  NUM_REQ  one-hot owner of the current transaction; 0 in IDLE
- `resp_done`  out  NUM_REQ  one-cycle pulse to owner at completion
- `resp_err`  out  1  valid with `resp_done`; 1 = timeout
- `resp_rdata`  out  32  read data, valid with `resp_done`; 0 on write or error
- `busy`  out  1  state != IDLE
- `ctrl_addr`  out  24  to controller `addr`
- `ctrl_wdata`  out  32  to controller `data_i`
- `ctrl_size`  out  3  to controller `size`
- `ctrl_rd_wr`  out  1  to controller `rd_wr`
- `ctrl_start`  out  1  one-cycle start pulse
- `ctrl_rdata`  in  32  from controller `data_o`
- `ctrl_done`  in  1  from controller `done`

## Operation
States:
- IDLE: if any `req_valid`, pick a winner with the round-robin pointer `ptr`.
  - The search starts at `ptr`; the lowest index at or after `ptr` wins, wrapping.
  - Register the winner's addr, rd_wr, size and wdata into the `ctrl_*` regs.
  - Set `grant` one-hot; set `ptr` = (winner+1) mod NUM_REQ. Go to ISSUE.
- ISSUE: `ctrl_start`=1 for exactly this cycle; clear timeout counter. Go to WAIT.
- WAIT: increment the timeout counter each cycle.
  - On `ctrl_done`: capture `ctrl_rdata` if read (else 0), set err=0, go to RESP.
  - Else, if the counter reaches TIMEOUT_CYCLES-1: rdata=0, err=1, go to RESP.
  - `ctrl_done` and timeout in the same cycle: `ctrl_done` wins, err=0.
- RESP: `resp_done[owner]`=1 for this cycle, with `resp_err` and `resp_rdata`. Go to IDLE; `grant` clears.

Rules:
- `ctrl_addr`, `ctrl_wdata`, `ctrl_size` and `ctrl_rd_wr` stay stable from ISSUE through RESP.
- Requester inputs are sampled only in IDLE. Changes or a dropped `req_valid` mid-transaction are ignored; the transaction completes and `resp_done` still pulses.
- `ctrl_done` arriving in IDLE, ISSUE or RESP is ignored.
- A requester re-asserting immediately after its `resp_done` competes normally. Round-robin guarantees every active requester is served within NUM_REQ transactions.

## Timing
- Reset values: all outputs 0, state IDLE, `ptr`=0, timeout counter 0.
- Reset mid-transaction returns to IDLE on the next edge without waiting for `ctrl_done`. The system must also reset the controller.
- Latency:
  - `req_valid` high in IDLE at cycle 0 → `grant` and `ctrl_*` valid at cycle 1 (ISSUE, `ctrl_start`=1).
  - `ctrl_done` at cycle D → `resp_done` at D+1.
  - IDLE at D+2, so a new `ctrl_start` is possible at D+3 at the earliest.
- Timeout: with no `ctrl_done`, `resp_done` with err=1 arrives at cycle TIMEOUT_CYCLES+2 after the IDLE sample.
- `busy`=1 from cycle 1 through the RESP cycle.

## Structure
- Package `psram_arb_pkg` holds:
  - state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3);
  - `PSRAM_ADDR_W`=24, `PSRAM_DATA_W`=32, `PSRAM_SIZE_W`=3.
- One combinational sub-module, `psram_rr_pick`:
  - inputs: request vector, `ptr`;
  - outputs: one-hot winner, winner index, `any` flag.
- The FSM, field mux, timeout counter and response registers live in the top level.

## Test plan
- Single read: req0 addr=0x000100, rd, ctrl model returns 0xDEADBEEF with done 5 cycles after start → `ctrl_start` at cycle 1, `resp_done[0]` 1 cycle after done, `resp_rdata`=0xDEADBEEF, err=0.
- Round-robin: all three requesters held valid for 6 transactions → grant order 0,1,2,0,1,2. Then with `ptr`=1 and only req0/req2 active → order 2,0.
- Write: req2 wr addr=0x001000 wdata=0x12345678 → `ctrl_wdata`=0x12345678 and `ctrl_rd_wr`=0 stable through RESP; `resp_rdata`=0.
- Timeout: TIMEOUT_CYCLES=16, controller never asserts done → `resp_done` with err=1, rdata=0, at cycle 18. Repeat with done exactly at the expiry cycle → err=0.
- Requester drops: req1 deasserts `req_valid` in WAIT → transaction completes and `resp_done[1]` still pulses. A stray `ctrl_done` in IDLE → no response.
- Reset mid-WAIT: assert `rst` for 1 cycle → next cycle all outputs 0 and `ptr`=0. The next request from req1 is granted normally.
